// File: rtl/csa_multiword_seq.sv
// Multi-cycle wide adder: one SLICE-bit carry-select adder is reused over WIDTH/SLICE
// cycles, least-significant slice first, with valid/ready handshakes on both sides.
module csa_multiword_seq #(
    parameter int WIDTH    = 32,
    parameter int SLICE    = 8,
    parameter int K        = 4,
    parameter int ADD_TYPE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             busy
);
    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = $clog2(NSL) + 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("csa_multiword_seq: WIDTH must be a multiple of SLICE");
    end
    if (K >= SLICE) begin : g_bad_split
        $error("csa_multiword_seq: K must be smaller than SLICE");
    end
    if (ADD_TYPE == 1 && (K != 4 || SLICE != 8)) begin : g_bad_cla
        $error("csa_multiword_seq: CLA slice requires K==4 and SLICE==8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_nx;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic [SLICE-1:0] s_sl;
    logic             c_sl;

    carryselect #(.N(SLICE), .K(K), .CLA(ADD_TYPE)) u_cs (
        .x   (a_q[SLICE-1:0]),
        .y   (b_q[SLICE-1:0]),
        .cin (carry_q),
        .s   (s_sl),
        .cout(c_sl)
    );

    // Each new slice enters at the top, so after NSL shifts slice 0 sits at the bottom.
    if (NSL == 1) begin : g_one_slice
        assign sum_nx = s_sl;
    end else begin : g_multi_slice
        assign sum_nx = {s_sl, sum_q[WIDTH-1:SLICE]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of a combinational block gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= ci;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_nx;
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    carry_q <= c_sl;
                    cnt     <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // sum_q holds partial slices during RUN; only the finished result is ever visible.
    assign sum = (state == DONE) ? sum_q : '0;
    assign co  = (state == DONE) ? carry_q : 1'b0;
endmodule

// Carry-select adder: low K bits add with the real carry-in, the high part is
// computed for both carry values and chosen by the low carry-out.
module carryselect #(
    parameter int N   = 8,
    parameter int K   = 4,
    parameter int CLA = 0
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [K-1:0]   s_lo;
    logic [N-K-1:0] s_hi0, s_hi1;
    logic           c_lo, c_hi0, c_hi1;

    csa_addblk #(.N(K), .CLA(CLA)) u_lo (
        .x(x[K-1:0]), .y(y[K-1:0]), .cin(cin), .s(s_lo), .cout(c_lo)
    );
    csa_addblk #(.N(N-K), .CLA(CLA)) u_hi0 (
        .x(x[N-1:K]), .y(y[N-1:K]), .cin(1'b0), .s(s_hi0), .cout(c_hi0)
    );
    csa_addblk #(.N(N-K), .CLA(CLA)) u_hi1 (
        .x(x[N-1:K]), .y(y[N-1:K]), .cin(1'b1), .s(s_hi1), .cout(c_hi1)
    );

    assign s    = {c_lo ? s_hi1 : s_hi0, s_lo};
    assign cout = c_lo ? c_hi1 : c_hi0;
endmodule

// N-bit adder block: ripple carry, or flattened lookahead carries when CLA != 0.
module csa_addblk #(
    parameter int N   = 4,
    parameter int CLA = 0
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N-1:0] g, p;
    logic [N:0]   c;
    logic         term;

    always_comb begin
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        term = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (CLA != 0) begin
                // c[i] = OR_j (g[j] & p[j+1..i-1]) | (cin & p[0..i-1])
                for (int j = 0; j < i; j++) begin
                    term = g[j];
                    for (int m = j + 1; m < i; m++) term = term & p[m];
                    c[i] = c[i] | term;
                end
                term = cin;
                for (int m = 0; m < i; m++) term = term & p[m];
                c[i] = c[i] | term;
            end else begin
                c[i] = g[i-1] | (p[i-1] & c[i-1]);
            end
        end
        s    = p ^ c[N-1:0];
        cout = c[N];
    end
endmodule

// File: tb/tb_csa_multiword_seq.sv
// Directed bench for csa_multiword_seq: CLA 8-bit slice instance plus an RCA
// 16-bit slice instance exercised with back-to-back random operations.
module tb_csa_multiword_seq;
    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Instance 1: WIDTH=32, SLICE=8, K=4, CLA
    logic        in_valid, in_ready, ci, out_valid, out_ready, co, busy;
    logic [31:0] a, b, sum;
    // Instance 2: WIDTH=32, SLICE=16, K=8, RCA
    logic        in_valid2, in_ready2, ci2, out_valid2, out_ready2, co2, busy2;
    logic [31:0] a2, b2, sum2;

    int errors = 0;
    int checks = 0;

    csa_multiword_seq #(.WIDTH(32), .SLICE(8), .K(4), .ADD_TYPE(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co), .busy(busy)
    );

    csa_multiword_seq #(.WIDTH(32), .SLICE(16), .K(8), .ADD_TYPE(0)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .ci(ci2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .co(co2), .busy(busy2)
    );

    // Present one operation to instance 1 and count edges until out_valid (bounded).
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                        output int lat);
        @(negedge clk);
        a = av; b = bv; ci = cv; in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic retire();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({out_valid, sum, co, busy} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b sum=%h co=%b busy=%b required all 0",
                     out_valid, sum, co, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] va [3] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] vb [3] = '{32'h0000_0002, 32'h0000_0001, 32'h8000_0000};
        logic        vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] es [3] = '{32'h0000_0003, 32'h0000_0000, 32'h0000_0001};
        logic        ec [3] = '{1'b0, 1'b1, 1'b1};
        int lat;
        for (int i = 0; i < 3; i++) begin
            send(va[i], vb[i], vc[i], lat);
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL basic%0d_latency: got %0d cycles required 4", i, lat);
            end
            checks++;
            if (sum !== es[i] || co !== ec[i]) begin
                errors++;
                $display("FAIL basic%0d_result: sum=%h co=%b required sum=%h co=%b",
                         i, sum, co, es[i], ec[i]);
            end
            retire();
        end
    endtask

    task automatic test_hold();
        int lat;
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                a = 32'hDEAD_BEEF; b = 32'h1111_1111; ci = 1'b1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 32'h0000_0100 || co !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b sum=%h co=%b required 1 0 00000100 0",
                         i, out_valid, in_ready, sum, co);
            end
        end
        retire();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sum !== 32'd0) begin
            errors++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b busy=%b sum=%h required 0 1 0 00000000",
                     out_valid, in_ready, busy, sum);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_ignored: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; ci = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, sum, co, busy} !== 35'd0) begin
            errors++;
            $display("FAIL midreset_outputs: out_valid=%b sum=%h co=%b busy=%b required all 0",
                     out_valid, sum, co, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_ready: in_ready=%b required 1", in_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet%0d: out_valid=%b busy=%b required 0 0",
                         i, out_valid, busy);
            end
        end
        send(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
        checks++;
        if (lat !== 4 || sum !== 32'h2345_6789 || co !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next: lat=%0d sum=%h co=%b required 4 23456789 0",
                     lat, sum, co);
        end
        retire();
    endtask

    task automatic test_back_to_back();
        int first, second, n;
        first  = -1;
        second = -1;
        @(negedge clk);
        a = 32'h0000_0005; b = 32'h0000_0007; ci = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        checks++;
        if (second - first !== 6 || first < 0) begin
            errors++;
            $display("FAIL b2b_interval: accepts at %0d and %0d, spacing %0d required 6",
                     first, second, second - first);
        end
    endtask

    task automatic test_random16();
        logic [32:0] exp;
        int lat, hold;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i == 0) begin
                a2 = 32'hFFFF_FFFF; b2 = 32'h0000_0000; ci2 = 1'b1;
            end else begin
                a2 = $urandom; b2 = $urandom; ci2 = 1'($urandom_range(0, 1));
            end
            exp = {1'b0, a2} + {1'b0, b2} + {32'd0, ci2};
            in_valid2 = 1'b1;
            @(posedge clk);
            #1 in_valid2 = 1'b0;
            lat = 0;
            while (out_valid2 !== 1'b1 && lat < 20) begin
                @(posedge clk);
                #1 lat++;
            end
            checks++;
            if (lat !== 2 || sum2 !== exp[31:0] || co2 !== exp[32]) begin
                errors++;
                $display("FAIL rand16_op%0d: lat=%0d sum=%h co=%b required 2 %h %b",
                         i, lat, sum2, co2, exp[31:0], exp[32]);
            end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) @(posedge clk);
            @(negedge clk);
            out_ready2 = 1'b1;
            @(posedge clk);
            #1 out_ready2 = 1'b0;
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
